// File: rtl/apple_spawn_ctrl.sv
// Apple game-step controller: hit detection, saturating score and eat pulses on tick,
// then an LFSR-driven draw/check/commit respawn for each eaten apple (good first).
module apple_spawn_ctrl #(
  parameter int          CELL      = 20,
  parameter int          GX_MIN    = 3,
  parameter int          GX_SPAN   = 28,
  parameter int          GY_MIN    = 3,
  parameter int          GY_SPAN   = 20,
  parameter int          HIT_R     = 30,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [9:0] headx,
  input  logic [9:0] heady,
  output logic [9:0] good_x,
  output logic [9:0] good_y,
  output logic [9:0] bad_x,
  output logic [9:0] bad_y,
  output logic [7:0] score,
  output logic       eat_good,
  output logic       eat_bad,
  output logic       busy
);

  localparam int TW = $clog2(MAX_TRIES);
  localparam logic signed [10:0] L_HIT   = 11'(HIT_R);
  localparam logic [9:0]         L_FB_PX = 10'(GX_MIN * CELL);
  localparam logic [9:0]         L_FB_PY = 10'(GY_MIN * CELL);
  localparam logic [4:0]         L_FB_C0 = 5'(GX_MIN);
  localparam logic [4:0]         L_FB_C1 = 5'(GX_MIN + GX_SPAN - 1);
  localparam logic [4:0]         L_FB_R  = 5'(GY_MIN);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_COMMIT} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_lfsr;
  logic [9:0]    r_good_x, r_good_y, r_bad_x, r_bad_y;
  logic [7:0]    r_score;
  logic          r_eat_good, r_eat_bad;
  logic          r_pend_good, r_pend_bad;
  logic [TW-1:0] r_tries;
  logic [4:0]    r_cand_c, r_cand_r;

  // Strict box test on 11-bit signed differences; |d| == HIT_R is a miss.
  function automatic logic hit(input logic [9:0] px, py, ax, ay);
    logic signed [10:0] dx, dy;
    dx = signed'({1'b0, px}) - signed'({1'b0, ax});
    dy = signed'({1'b0, py}) - signed'({1'b0, ay});
    return (dx > -L_HIT) && (dx < L_HIT) && (dy > -L_HIT) && (dy < L_HIT);
  endfunction

  logic       w_fb, w_hit_good, w_hit_bad, w_eat_g, w_eat_b;
  logic [9:0] w_cand_px, w_cand_py, w_oth_x, w_oth_y;
  logic [4:0] w_draw_c, w_draw_r;
  logic       w_reject, w_last_try, w_fb_alt;

  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_hit_good = hit(headx, heady, r_good_x, r_good_y);
  assign w_hit_bad  = hit(headx, heady, r_bad_x, r_bad_y);
  assign w_eat_g    = (r_state == S_IDLE) && tick && w_hit_good;
  assign w_eat_b    = (r_state == S_IDLE) && tick && w_hit_bad;

  assign w_draw_c   = 5'(GX_MIN + 32'(r_lfsr[7:0]) % GX_SPAN);
  assign w_draw_r   = 5'(GY_MIN + 32'(r_lfsr[15:8]) % GY_SPAN);
  assign w_cand_px  = 10'(r_cand_c) * 10'(CELL);
  assign w_cand_py  = 10'(r_cand_r) * 10'(CELL);

  // While good is pending it is the one being respawned; the other apple blocks its cell.
  assign w_oth_x    = r_pend_good ? r_bad_x : r_good_x;
  assign w_oth_y    = r_pend_good ? r_bad_y : r_good_y;
  assign w_reject   = hit(headx, heady, w_cand_px, w_cand_py) ||
                      ((w_cand_px == w_oth_x) && (w_cand_py == w_oth_y));
  assign w_last_try = (r_tries == TW'(MAX_TRIES - 1));
  assign w_fb_alt   = (L_FB_PX == w_oth_x) && (L_FB_PY == w_oth_y);

  // NOTE: asynchronous reset clears every register, including the LFSR and FSM,
  // so an aborted respawn leaves no stale candidate or pending flag behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_eat_g || w_eat_b) w_next = S_DRAW;
      S_DRAW:   w_next = S_CHECK;
      S_CHECK:  w_next = (w_reject && !w_last_try) ? S_DRAW : S_COMMIT;
      S_COMMIT: w_next = (r_pend_good && r_pend_bad) ? S_DRAW : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr      <= LFSR_SEED;
      r_good_x    <= 10'd320;
      r_good_y    <= 10'd240;
      r_bad_x     <= 10'd20;
      r_bad_y     <= 10'd20;
      r_score     <= '0;
      r_eat_good  <= 1'b0;
      r_eat_bad   <= 1'b0;
      r_pend_good <= 1'b0;
      r_pend_bad  <= 1'b0;
      r_tries     <= '0;
      r_cand_c    <= '0;
      r_cand_r    <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], w_fb};
      r_eat_good <= w_eat_g;
      r_eat_bad  <= w_eat_b;
      case (r_state)
        S_IDLE: begin
          if (w_eat_g) r_pend_good <= 1'b1;
          if (w_eat_b) r_pend_bad  <= 1'b1;
          case ({w_eat_g, w_eat_b})
            2'b10:   if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            2'b01:   if (r_score != 8'h00) r_score <= r_score - 8'd1;
            default: r_score <= r_score;
          endcase
        end
        S_DRAW: begin
          r_cand_c <= w_draw_c;
          r_cand_r <= w_draw_r;
        end
        S_CHECK: begin
          if (w_reject) begin
            if (!w_last_try) begin
              r_tries <= r_tries + TW'(1);
            end else begin
              r_cand_c <= w_fb_alt ? L_FB_C1 : L_FB_C0;
              r_cand_r <= L_FB_R;
            end
          end
        end
        S_COMMIT: begin
          r_tries <= '0;
          if (r_pend_good) begin
            r_good_x    <= w_cand_px;
            r_good_y    <= w_cand_py;
            r_pend_good <= 1'b0;
          end else begin
            r_bad_x    <= w_cand_px;
            r_bad_y    <= w_cand_py;
            r_pend_bad <= 1'b0;
          end
        end
        default: r_tries <= '0;
      endcase
    end
  end

  assign good_x   = r_good_x;
  assign good_y   = r_good_y;
  assign bad_x    = r_bad_x;
  assign bad_y    = r_bad_y;
  assign score    = r_score;
  assign eat_good = r_eat_good;
  assign eat_bad  = r_eat_bad;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: directed and random head positions checked against a
// transaction-level model of scoring and respawn placement.
module tb_apple_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] headx = '0, heady = '0;
  logic [9:0] good_x, good_y, bad_x, bad_y;
  logic [7:0] score;
  logic       eat_good, eat_bad, busy;

  apple_spawn_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .headx(headx), .heady(heady),
    .good_x(good_x), .good_y(good_y), .bad_x(bad_x), .bad_y(bad_y),
    .score(score), .eat_good(eat_good), .eat_bad(eat_bad), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int m_gx = 320, m_gy = 240, m_bx = 20, m_by = 20, m_score = 0;
  logic seen_g, seen_b;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Free-running sequence the DUT draws from; restarts with every reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lstep(m_lfsr);
  end

  function automatic bit mhit(input int hx, hy, ax, ay);
    int dx, dy;
    dx = hx - ax;
    dy = hy - ay;
    return (dx > -30) && (dx < 30) && (dy > -30) && (dy < 30);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Placement of one apple: up to 8 draws two cycles apart, then the fixed fallback.
  // cyc = cycles from the tick (or the previous commit) to this apple's commit.
  task automatic spawn(input logic [15:0] l_in, input int hx, hy, ox, oy,
                       output int px, output int py, output int cyc);
    logic [15:0] l;
    l = l_in;
    for (int k = 0; k < 8; k++) begin
      px = (3 + int'(l[7:0]) % 28) * 20;
      py = (3 + int'(l[15:8]) % 20) * 20;
      if (!(mhit(hx, hy, px, py) || (px == ox && py == oy))) begin
        cyc = 2 * k + 3;
        return;
      end
      l = lstep(lstep(l));
    end
    py  = 60;
    px  = (ox == 60 && oy == 60) ? 600 : 60;
    cyc = 17;
  endtask

  task automatic do_tick(input int hx, input int hy, input bit extra);
    bit hg, hb, done;
    int ngx, ngy, ngc, nbx, nby, nbc, tot, rel;
    logic [15:0] l0, lb;
    @(negedge clk);
    headx = 10'(hx);
    heady = 10'(hy);
    tick  = 1'b1;
    hg = mhit(hx, hy, m_gx, m_gy);
    hb = mhit(hx, hy, m_bx, m_by);
    @(posedge clk);
    #1;
    tick = 1'b0;
    l0 = m_lfsr;
    seen_g = eat_good;
    seen_b = eat_bad;
    check("eat_good", 32'(eat_good), 32'(hg));
    check("eat_bad", 32'(eat_bad), 32'(hb));
    if (hg && !hb && m_score < 255) m_score++;
    else if (hb && !hg && m_score > 0) m_score--;
    check("score", 32'(score), 32'(m_score));
    check("busy_after_tick", 32'(busy), 32'(hg | hb));
    if (!(hg || hb)) return;

    ngc = 0;
    lb  = l0;
    ngx = m_gx; ngy = m_gy;
    if (hg) begin
      spawn(l0, hx, hy, m_bx, m_by, ngx, ngy, ngc);
      for (int i = 0; i < ngc; i++) lb = lstep(lb);
    end
    nbc = 0;
    nbx = m_bx; nby = m_by;
    if (hb) spawn(lb, hx, hy, ngx, ngy, nbx, nby, nbc);
    tot = ngc + nbc;

    rel  = 0;
    done = 1'b0;
    while (!done && rel < 60) begin
      tick = extra && (rel < 2);
      @(posedge clk);
      #1;
      tick = 1'b0;
      rel++;
      check("no_extra_pulse", 32'({eat_good, eat_bad}), 32'(0));
      if (hg && hb && rel == ngc) begin
        check("good_first", 32'({good_x, good_y}), 32'({10'(ngx), 10'(ngy)}));
        check("bad_still_old", 32'({bad_x, bad_y}), 32'({10'(m_bx), 10'(m_by)}));
      end
      if (!busy) done = 1'b1;
    end
    check("respawn_cycles", 32'(rel), 32'(tot));
    m_gx = ngx; m_gy = ngy; m_bx = nbx; m_by = nby;
    check("good_pos", 32'({good_x, good_y}), 32'({10'(m_gx), 10'(m_gy)}));
    check("bad_pos", 32'({bad_x, bad_y}), 32'({10'(m_bx), 10'(m_by)}));
    check("score_hold", 32'(score), 32'(m_score));
    if (hg)
      check("good_on_grid", 32'(good_x % 20 == 0 && good_x >= 60 && good_x <= 600 &&
                                good_y % 20 == 0 && good_y >= 60 && good_y <= 440), 32'(1));
    if (hb)
      check("bad_on_grid", 32'(bad_x % 20 == 0 && bad_x >= 60 && bad_x <= 600 &&
                               bad_y % 20 == 0 && bad_y >= 60 && bad_y <= 440), 32'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_good"}, 32'({good_x, good_y}), 32'({10'd320, 10'd240}));
    check({tag, "_bad"}, 32'({bad_x, bad_y}), 32'({10'd20, 10'd20}));
    check({tag, "_score"}, 32'(score), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_eat"}, 32'({eat_good, eat_bad}), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hx, hy, base_x, base_y, sel, guard;
    bit found;

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    // Poison eaten at score 0 keeps score at 0.
    do_tick(20, 20, 0);
    check("score_floor", 32'(score), 32'(0));

    // Hit-radius boundary around the good apple at (320,240).
    do_tick(350, 240, 0);
    do_tick(290, 240, 0);
    do_tick(320, 270, 0);
    do_tick(349, 240, 0);

    // Ticks while busy are dropped.
    do_tick(m_gx, m_gy, 1);

    // Random heads near either apple or anywhere on the field.
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 2));
      base_x = (sel == 0) ? m_gx : (sel == 1) ? m_bx : int'($urandom_range(0, 639));
      base_y = (sel == 0) ? m_gy : (sel == 1) ? m_by : int'($urandom_range(0, 479));
      hx = base_x + int'($urandom_range(0, 70)) - 35;
      hy = base_y + int'($urandom_range(0, 70)) - 35;
      if (hx < 0) hx = 0;
      if (hy < 0) hy = 0;
      do_tick(hx, hy, 0);
    end

    // Eat apples until both sit within reach of one head position, then hit both.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 600) begin
      if ((m_gx - m_bx) <= 40 && (m_bx - m_gx) <= 40 &&
          (m_gy - m_by) <= 40 && (m_by - m_gy) <= 40) begin
        found = 1'b1;
      end else begin
        if (guard % 4 == 3) do_tick(m_bx, m_by, 0);
        else                do_tick(m_gx, m_gy, 0);
        guard++;
      end
    end
    do_tick((m_gx + m_bx) / 2, (m_gy + m_by) / 2, 0);
    check("double_pulses", 32'({seen_g, seen_b}), 32'(2'b11));

    // Reset asserted while the respawn is in CHECK.
    @(negedge clk);
    headx = 10'(m_gx);
    heady = 10'(m_gy);
    tick  = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("busy_before_abort", 32'(busy), 32'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    m_gx = 320; m_gy = 240; m_bx = 20; m_by = 20; m_score = 0;
    @(negedge clk);
    check_reset_values("post_abort");

    // Score saturates at 255.
    guard = 0;
    while (m_score < 255 && guard < 400) begin
      do_tick(m_gx, m_gy, 0);
      guard++;
    end
    do_tick(m_gx, m_gy, 0);
    do_tick(m_gx, m_gy, 0);
    check("score_ceiling", 32'(score), 32'(255));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
